// File: rtl/edge_update_queue_if.sv
// Bus bundle for edge_update_queue: Avalon-MM slave register port plus the
// update handshake toward the path-search engine.
interface edge_update_queue_if #(
  parameter int NODE_W   = 3,
  parameter int WEIGHT_W = 32
);
  logic                chipselect;
  logic                write;
  logic                read;
  logic [2:0]          address;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic                upd_start;
  logic [NODE_W-1:0]   upd_src;
  logic [NODE_W-1:0]   upd_dst;
  logic [WEIGHT_W-1:0] upd_weight;
  logic                upd_done;

  modport slave (
    input  chipselect, write, read, address, writedata, upd_done,
    output readdata, upd_start, upd_src, upd_dst, upd_weight
  );

  modport master (
    output chipselect, write, read, address, writedata, upd_done,
    input  readdata, upd_start, upd_src, upd_dst, upd_weight
  );
endinterface

// File: rtl/edge_update_queue.sv
// Queues software-written edge updates in a FIFO and issues them one at a
// time to the path-search engine, waiting for upd_done between updates.
module edge_update_queue #(
  parameter int NODE_W   = 3,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                reset,
  edge_update_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * NODE_W + WEIGHT_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic                r_overflow;
  logic [NODE_W-1:0]   r_stg_src;
  logic [NODE_W-1:0]   r_stg_dst;
  logic [NODE_W-1:0]   r_upd_src;
  logic [NODE_W-1:0]   r_upd_dst;
  logic [WEIGHT_W-1:0] r_upd_weight;
  logic                r_upd_start;
  logic [ENT_W-1:0]    r_mem [DEPTH];

  logic             w_wr;
  logic             w_stage;
  logic             w_commit;
  logic             w_ctrl;
  logic             w_clr_ovf;
  logic             w_flush;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [ENT_W-1:0] w_entry;
  logic [7:0]       w_cnt8;
  logic [31:0]      w_status;

  assign w_wr      = bus.chipselect & bus.write;
  assign w_stage   = w_wr && (bus.address == 3'd0);
  assign w_commit  = w_wr && (bus.address == 3'd1);
  assign w_ctrl    = w_wr && (bus.address == 3'd2);
  assign w_clr_ovf = w_ctrl & bus.writedata[0];
  assign w_flush   = w_ctrl & bus.writedata[1];

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // A flush empties the queue, so it also suppresses a pop in the same cycle.
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !w_flush;
  assign w_push  = w_commit && !w_flush && (!w_full || w_pop);
  assign w_drop  = w_commit && !w_flush && w_full && !w_pop;
  assign w_entry = {r_stg_src, r_stg_dst, bus.writedata[WEIGHT_W-1:0]};

  assign w_cnt8   = 8'(r_count);
  assign w_status = {20'd0, w_empty, w_full, (r_state != S_IDLE), r_overflow, w_cnt8};

  assign bus.readdata   = (bus.chipselect && bus.read && bus.address == 3'd3) ? w_status : 32'd0;
  assign bus.upd_start  = r_upd_start;
  assign bus.upd_src    = r_upd_src;
  assign bus.upd_dst    = r_upd_dst;
  assign bus.upd_weight = r_upd_weight;

  // NOTE: the storage array has no reset; count and pointers define which
  // entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, e.g. the head read above a same-edge push.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_stg_src  <= '0;
      r_stg_dst  <= '0;
    end else begin
      if (w_stage) begin
        r_stg_src <= bus.writedata[2*NODE_W-1:NODE_W];
        r_stg_dst <= bus.writedata[NODE_W-1:0];
      end
      if (w_clr_ovf)   r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;

      if (w_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Update sequencer: pop into the output registers, pulse start, await done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_upd_start  <= 1'b0;
      r_upd_src    <= '0;
      r_upd_dst    <= '0;
      r_upd_weight <= '0;
    end else begin
      r_upd_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_upd_src, r_upd_dst, r_upd_weight} <= r_mem[r_rd_ptr];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_upd_start <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.upd_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_update_queue.sv
// Self-checking bench for edge_update_queue: directed scenarios plus random
// register traffic, compared every cycle against a queue-based reference model.
module tb_edge_update_queue;
  localparam int NODE_W   = 3;
  localparam int WEIGHT_W = 32;
  localparam int DEPTH    = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  edge_update_queue_if #(.NODE_W(NODE_W), .WEIGHT_W(WEIGHT_W)) bus ();

  edge_update_queue #(.NODE_W(NODE_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NODE_W-1:0]   src;
    logic [NODE_W-1:0]   dst;
    logic [WEIGHT_W-1:0] w;
  } ent_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries, a sticky flag and the
  // three-phase update handshake (0 idle, 1 popped, 2 waiting for done).
  ent_t              m_q[$];
  bit                m_ovf   = 0;
  int                m_phase = 0;
  ent_t              m_cur   = '0;
  logic [NODE_W-1:0] m_stg_src = '0;
  logic [NODE_W-1:0] m_stg_dst = '0;
  bit                m_start = 0;
  bit                m_live  = 0;

  task automatic model_step();
    bit   wr, flush, pop;
    ent_t e;
    if (reset) begin
      m_q.delete();
      m_ovf = 0; m_phase = 0; m_cur = '0; m_start = 0;
      m_stg_src = '0; m_stg_dst = '0; m_live = 1;
    end else if (m_live) begin
      wr    = bus.chipselect && bus.write;
      flush = wr && bus.address == 3'd2 && bus.writedata[1];
      pop   = (m_phase == 0) && (m_q.size() > 0) && !flush;
      m_start = (m_phase == 1);
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && bus.upd_done) m_phase = 0;
      if (pop) begin
        m_cur   = m_q.pop_front();
        m_phase = 1;
      end
      if (wr) begin
        case (bus.address)
          3'd0: begin
            m_stg_src = bus.writedata[2*NODE_W-1:NODE_W];
            m_stg_dst = bus.writedata[NODE_W-1:0];
          end
          3'd1: begin
            if (m_q.size() < DEPTH) begin
              e.src = m_stg_src; e.dst = m_stg_dst; e.w = bus.writedata[WEIGHT_W-1:0];
              m_q.push_back(e);
            end else m_ovf = 1;
          end
          3'd2: begin
            if (bus.writedata[0]) m_ovf = 0;
            if (bus.writedata[1]) m_q.delete();
          end
          default: ;
        endcase
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle once the model has seen reset.
  int          n_start = 0;
  bit          rec_en  = 0;
  logic [31:0] seen_w[$];

  initial forever begin
    logic [31:0] st, exp_rd;
    int sz;
    @(negedge clk);
    if (m_live) begin
      sz = m_q.size();
      st = {20'd0, sz == 0, sz == DEPTH, m_phase != 0, m_ovf, 8'(sz)};
      exp_rd = (bus.chipselect && bus.read && bus.address == 3'd3) ? st : 32'd0;
      check("upd_start",  {31'd0, bus.upd_start}, {31'd0, m_start});
      check("upd_src",    32'(bus.upd_src), 32'(m_cur.src));
      check("upd_dst",    32'(bus.upd_dst), 32'(m_cur.dst));
      check("upd_weight", bus.upd_weight, m_cur.w);
      check("readdata",   bus.readdata, exp_rd);
      if (bus.upd_start) begin
        n_start++;
        if (rec_en) seen_w.push_back(bus.upd_weight);
      end
    end
  end

  // Engine stand-in: the only driver of upd_done.
  int done_dly  = 0;
  int done_cnt  = 0;
  bit done_req  = 0;
  bit rand_done = 0;

  initial forever begin
    @(negedge clk);
    bus.upd_done = 1'b0;
    if (done_req) begin bus.upd_done = 1'b1; done_req = 0; end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus.upd_done = 1'b1;
    end
    if (bus.upd_start && done_dly > 0) done_cnt = done_dly;
    if (rand_done && $urandom_range(0, 3) == 0) bus.upd_done = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    cyc(1);
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 3'd0; bus.writedata = 32'd0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 3'd3;
    @(negedge clk);
    v = bus.readdata;
    cyc(1);
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.address = 3'd0;
  endtask

  task automatic wait_start(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.upd_start && k < limit);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((m_phase != 0 || m_q.size() != 0) && k < limit) begin
      cyc(1);
      k++;
    end
    check("drain_timeout", {31'd0, k < limit}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int k, s0;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = 3'd0; bus.writedata = 32'd0; bus.upd_done = 1'b0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;

    rd_status(v);
    check("reset_status", v, 32'h0000_0800);

    // Single update: src=1, dst=3.
    bus_wr(3'd0, 32'h0000_000B);
    bus_wr(3'd1, 32'hFFFF_FF80);
    wait_start(10, k);
    check("start_latency", k, 3);
    check("single_src", 32'(bus.upd_src), 32'd1);
    check("single_dst", 32'(bus.upd_dst), 32'd3);
    check("single_weight", bus.upd_weight, 32'hFFFF_FF80);
    cyc(1);
    rd_status(v);
    check("single_busy", v, 32'h0000_0A00);
    done_req = 1;
    cyc(2);
    rd_status(v);
    check("single_idle", v, 32'h0000_0800);

    // Fill: one in flight, eight queued, then overflow and clear.
    bus_wr(3'd0, 32'h0000_002A);
    for (int i = 0; i < 9; i++) bus_wr(3'd1, 32'd100 + 32'(i));
    rd_status(v);
    check("fill_full", v, 32'h0000_0608);
    check("fill_inflight", bus.upd_weight, 32'd100);
    bus_wr(3'd1, 32'd999);
    rd_status(v);
    check("fill_overflow", v, 32'h0000_0708);
    bus_wr(3'd2, 32'h1);
    rd_status(v);
    check("fill_ovf_clear", v, 32'h0000_0608);

    // Full with simultaneous pop: done lands, the pop edge carries a push.
    done_req = 1;
    cyc(1);
    bus_wr(3'd1, 32'd555);
    done_dly = 2;
    rd_status(v);
    check("full_pop_push", v, 32'h0000_0608);
    wait_drain(300);

    // Ordering and pointer wrap.
    done_dly = 4;
    rec_en = 1;
    for (int i = 1; i <= 20; i++) begin
      bus_wr(3'd1, 32'(i));
      cyc(5);
    end
    wait_drain(400);
    rec_en = 0;
    check("order_count", seen_w.size(), 32'd20);
    for (int i = 0; i < 20 && i < seen_w.size(); i++) check("order_weight", seen_w[i], 32'(i + 1));

    // Flush with one in flight, then reset during WAIT.
    done_dly = 0;
    bus_wr(3'd0, 32'h0000_0031);
    for (int i = 0; i < 6; i++) bus_wr(3'd1, 32'h50 + 32'(i));
    rd_status(v);
    check("flush_pre", v, 32'h0000_0205);
    bus_wr(3'd2, 32'h2);
    rd_status(v);
    check("flush_status", v, 32'h0000_0A00);
    check("flush_hold_w", bus.upd_weight, 32'h50);
    check("flush_hold_src", 32'(bus.upd_src), 32'd6);
    done_req = 1;
    cyc(2);
    bus_wr(3'd1, 32'h77);
    wait_start(10, k);
    check("reuse_stage_w", bus.upd_weight, 32'h77);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_weight", bus.upd_weight, 32'd0);
    check("rst_src", 32'(bus.upd_src), 32'd0);
    cyc(1);
    rd_status(v);
    check("rst_status", v, 32'h0000_0800);
    s0 = n_start;
    done_req = 1;
    cyc(8);
    check("rst_no_start", n_start, s0);

    // Random register traffic with random engine completions.
    rand_done = 1;
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.chipselect = ($urandom_range(0, 7) != 0);
      bus.write = 1'b0; bus.read = 1'b0;
      bus.writedata = $urandom();
      if (r < 2) begin
        bus.write = 1'b1; bus.address = 3'd0;
      end else if (r < 6) begin
        bus.write = 1'b1; bus.address = 3'd1;
      end else if (r == 6) begin
        bus.write = 1'b1; bus.address = 3'd2;
        bus.writedata = {30'd0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
      end else if (r == 7) begin
        bus.read = 1'b1; bus.address = 3'($urandom_range(0, 7));
      end else if (r == 8) begin
        bus.write = 1'b1; bus.address = 3'($urandom_range(3, 7));
      end else begin
        bus.chipselect = 1'b0; bus.address = 3'd3; bus.read = 1'b1;
      end
      cyc(1);
    end
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = 3'd0; bus.writedata = 32'd0;
    wait_drain(600);
    rand_done = 0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/edge_update_queue.md
EDGE_UPDATE_QUEUE -- requirements
Module: edge_update_queue

Interface
Parameters:
REQ-001 NODE_W, default 3: node index width in bits.
REQ-002 WEIGHT_W, default 32: edge weight width in bits.
REQ-003 DEPTH, default 8: FIFO entries; SHALL be a power of two, at least 2.

Ports:
REQ-004 clk  in  1  system clock; reset  in  1  synchronous, active-high.
REQ-005 chipselect  in  1  Avalon slave select.
REQ-006 write  in  1  Avalon write strobe, qualified by chipselect.
REQ-007 read  in  1  Avalon read strobe, qualified by chipselect.
REQ-008 address  in  3  register select.
REQ-009 writedata  in  32  Avalon write data.
REQ-010 readdata  out  32  status word.
REQ-011 upd_start  out  1  one-cycle pulse that launches one edge update in the path-search engine.
REQ-012 upd_src  out  NODE_W  source node of the current update.
REQ-013 upd_dst  out  NODE_W  destination node of the current update.
REQ-014 upd_weight  out  WEIGHT_W  log-rate weight of the current update.
REQ-015 upd_done  in  1  pulse from the engine; the current update has finished.

Function
REQ-016 A write occurs when chipselect=1 and write=1.
REQ-017 Write to address 0 SHALL stage the pair: src from writedata[2*NODE_W-1:NODE_W], dst from writedata[NODE_W-1:0].
REQ-018 Write to address 1 SHALL commit {staged src, staged dst, writedata[WEIGHT_W-1:0]} as one FIFO push.
- Staged src/dst are retained after the commit, so repeated address-1 writes reuse them.
REQ-019 Write to address 2 SHALL act on control bits.
- bit0=1: clear the overflow flag.
- bit1=1: flush; FIFO count becomes 0 at the next edge.
- Flush SHALL NOT abort an in-flight update.
REQ-020 Writes to addresses 3-7 SHALL have no effect.
REQ-021 readdata is combinational from registered state, valid in the same cycle as the read.
- Address 3 SHALL return: [7:0] FIFO count, [8] overflow, [9] busy (state not IDLE), [10] full, [11] empty.
- Any other address SHALL return 0.
REQ-022 Push when count<DEPTH SHALL be accepted.
REQ-023 Push when count=DEPTH with no pop in the same cycle SHALL be dropped and set overflow (sticky).
REQ-024 Push when count=DEPTH with a pop in the same cycle SHALL be accepted; count stays DEPTH.
REQ-025 Flush and push in the same cycle: flush wins; push dropped; overflow not set.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; entries pop in push order.
REQ-027 FSM states: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when count>0: pop the head entry and register it onto upd_src/upd_dst/upd_weight at that edge.
- ISSUE: upd_start=1 for exactly one cycle; -> WAIT.
- WAIT -> IDLE on upd_done=1.
- upd_done outside WAIT SHALL be ignored.
REQ-028 upd_src/upd_dst/upd_weight SHALL hold stable from ISSUE until the next pop.
REQ-029 Latency: an accepted commit at edge E into an empty queue with FSM in IDLE SHALL give upd_start=1 in the cycle following edge E+2.
REQ-030 Back-to-back throughput: at most one update per 3 cycles; the next pop may occur at the edge where upd_done is sampled in WAIT plus one.

Reset
REQ-031 On reset, the following SHALL be set:
- state=IDLE, count=0, pointers=0, overflow=0.
- staged src/dst=0; upd_src/upd_dst/upd_weight=0.
- upd_start=0; readdata=0 for any non-status address.
REQ-032 Reset mid-update SHALL discard the in-flight update and all queued entries; upd_done arriving after reset SHALL be ignored.

Verification
REQ-033 Single update: addr0 write 0x0000000B (src=1, dst=3); addr1 write 0xFFFFFF80.
- upd_start pulses once, 3 cycles after the addr1 edge.
- upd_src=1, upd_dst=3, upd_weight=0xFFFFFF80.
- Status reads busy=1 until upd_done.
REQ-034 Fill: with upd_done held 0, commit 9 entries.
- The first pops, the next 8 queue, count=8, full=1.
- A 10th commit is dropped and overflow=1.
- addr2 write 0x1 clears overflow.
REQ-035 Ordering/wrap: commit weights 1..20 while pulsing upd_done 4 cycles after each upd_start.
- upd_weight sequence is exactly 1..20, no duplicates or gaps.
REQ-036 Full with simultaneous pop: count=DEPTH and state IDLE, then push in the same cycle as the pop.
- count stays DEPTH; overflow stays 0.
REQ-037 Flush and reset: with 5 queued and 1 in flight, addr2 write 0x2.
- count=0; the in-flight outputs hold until upd_done.
- Assert reset during the next WAIT: all outputs 0, status=0x800, a later upd_done causes no upd_start.
